// File: rtl/logic1_pkg.sv
// Shared types and constant tables for the logic1 sequence checker.
// Tables are packed with step 0 in the least-significant pair.
package logic1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } l1_state_e;

    localparam int L1_TABLE_DEPTH = 8;
    localparam int L1_ERR_W       = 6;
    localparam int L1_IO_W        = 2;

    // X applied at each step, and the {Z1,Z2} a correct unit answers with.
    localparam logic [L1_IO_W*L1_TABLE_DEPTH-1:0] L1_X_TABLE = 16'b01_11_10_00_01_11_01_00;
    localparam logic [L1_IO_W*L1_TABLE_DEPTH-1:0] L1_Z_TABLE = 16'b00_00_01_10_10_11_00_00;

    function automatic logic [L1_IO_W-1:0] l1_lookup(
        input logic [L1_IO_W*L1_TABLE_DEPTH-1:0] tbl,
        input logic [2:0]                        step
    );
        return tbl[{step, 1'b0} +: L1_IO_W];
    endfunction

endpackage

// File: rtl/logic1_step_cmp.sv
// Combinational compare of both units' {Z1,Z2} against the expected pair.
module logic1_step_cmp
    import logic1_pkg::*;
(
    input  logic [L1_IO_W-1:0] i_z_behav,
    input  logic [L1_IO_W-1:0] i_z_struc,
    input  logic [L1_IO_W-1:0] i_exp,
    output logic               o_behav_mis,
    output logic               o_struc_mis
);

    logic [L1_IO_W-1:0] w_behav_diff;
    logic [L1_IO_W-1:0] w_struc_diff;

    genvar gi;
    generate
        for (gi = 0; gi < L1_IO_W; gi++) begin : g_bit
            assign w_behav_diff[gi] = i_z_behav[gi] ^ i_exp[gi];
            assign w_struc_diff[gi] = i_z_struc[gi] ^ i_exp[gi];
        end
    endgenerate

    assign o_behav_mis = |w_behav_diff;
    assign o_struc_mis = |w_struc_diff;

endmodule

// File: rtl/logic1_seq_checker.sv
// Plays the 8-step X table into both logic units and scores their Z outputs.
// Define LOGIC1_SEQ_REPEAT_EN to make every run two back-to-back passes.
module logic1_seq_checker
    import logic1_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int NUM_STEPS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          z_behav,
    input  logic [1:0]          z_struc,
    output logic [1:0]          x_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [L1_ERR_W-1:0] err_count,
    output logic                behav_err,
    output logic                struc_err,
    output logic [3:0]          first_fail
);

    localparam logic [7:0]          LAST_CNT  = 8'(STEP_CYCLES - 1);
    localparam logic [2:0]          LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [L1_ERR_W-1:0] ERR_MAX   = {L1_ERR_W{1'b1}};
`ifdef LOGIC1_SEQ_REPEAT_EN
    localparam logic                LAST_PASS = 1'b1;
`else
    localparam logic                LAST_PASS = 1'b0;
`endif

    l1_state_e           r_state, w_state_next;
    logic [2:0]          r_step, w_step_next;
    logic [7:0]          r_cnt, w_cnt_next;
    logic                r_pass_idx, w_pass_idx_next;
    logic [1:0]          r_x, w_x_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic                r_pass, w_pass_next;
    logic [L1_ERR_W-1:0] r_err_count, w_err_next;
    logic                r_behav_err, w_behav_next;
    logic                r_struc_err, w_struc_next;
    logic [3:0]          r_first_fail, w_ff_next;

    logic                w_behav_mis, w_struc_mis, w_mis;
    logic [2:0]          w_step_inc;

    assign w_step_inc = r_step + 3'd1;
    assign w_mis      = w_behav_mis | w_struc_mis;

    logic1_step_cmp u_cmp (
        .i_z_behav   (z_behav),
        .i_z_struc   (z_struc),
        .i_exp       (l1_lookup(L1_Z_TABLE, r_step)),
        .o_behav_mis (w_behav_mis),
        .o_struc_mis (w_struc_mis)
    );

    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_cnt_next      = r_cnt;
        w_pass_idx_next = r_pass_idx;
        w_x_next        = r_x;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_pass_next     = r_pass;
        w_err_next      = r_err_count;
        w_behav_next    = r_behav_err;
        w_struc_next    = r_struc_err;
        w_ff_next       = r_first_fail;

        case (r_state)
            ST_IDLE: begin
                w_x_next    = 2'b00;
                w_busy_next = 1'b0;
                if (start) begin
                    w_state_next    = ST_DRIVE;
                    w_step_next     = 3'd0;
                    w_cnt_next      = 8'd0;
                    w_pass_idx_next = 1'b0;
                    w_x_next        = l1_lookup(L1_X_TABLE, 3'd0);
                    w_busy_next     = 1'b1;
                    w_pass_next     = 1'b0;
                    w_err_next      = '0;
                    w_behav_next    = 1'b0;
                    w_struc_next    = 1'b0;
                    w_ff_next       = 4'd0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == LAST_CNT) begin
                    // Sample edge: score this step, then move the vector on.
                    w_cnt_next   = 8'd0;
                    w_behav_next = r_behav_err | w_behav_mis;
                    w_struc_next = r_struc_err | w_struc_mis;
                    if (w_mis) begin
                        if (r_err_count != ERR_MAX) begin
                            w_err_next = r_err_count + {{(L1_ERR_W-1){1'b0}}, 1'b1};
                        end
                        if (r_err_count == '0) begin
                            w_ff_next = {r_pass_idx, r_step};
                        end
                    end
                    if (r_step == LAST_STEP) begin
                        if (r_pass_idx == LAST_PASS) begin
                            w_state_next = ST_DONE;
                            w_x_next     = 2'b00;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                            w_pass_next  = (r_err_count == '0) && !w_mis;
                        end else begin
                            w_pass_idx_next = 1'b1;
                            w_step_next     = 3'd0;
                            w_x_next        = l1_lookup(L1_X_TABLE, 3'd0);
                        end
                    end else begin
                        w_step_next = w_step_inc;
                        w_x_next    = l1_lookup(L1_X_TABLE, w_step_inc);
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_step       <= 3'd0;
            r_cnt        <= 8'd0;
            r_pass_idx   <= 1'b0;
            r_x          <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_behav_err  <= 1'b0;
            r_struc_err  <= 1'b0;
            r_first_fail <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_step       <= w_step_next;
            r_cnt        <= w_cnt_next;
            r_pass_idx   <= w_pass_idx_next;
            r_x          <= w_x_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_err_count  <= w_err_next;
            r_behav_err  <= w_behav_next;
            r_struc_err  <= w_struc_next;
            r_first_fail <= w_ff_next;
        end
    end

    assign x_out      = r_x;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign behav_err  = r_behav_err;
    assign struc_err  = r_struc_err;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_logic1_seq_checker.sv
// Bench for logic1_seq_checker: table vectors, corner sequences, random runs vs. a run-level model.
module tb_logic1_seq_checker;

    localparam int SC = 4;
    localparam int NS = 8;
`ifdef LOGIC1_SEQ_REPEAT_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    typedef logic [1:0] zarr_t [16];

    typedef struct {
        logic [7:0] bmask;
        logic [1:0] bval;
        logic [7:0] smask;
        logic [1:0] sval;
        int         err_pp;
        logic       be;
        logic       se;
        logic [3:0] ff;
        logic       pass;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] z_behav, z_struc;
    logic [1:0] x_out;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic       behav_err, struc_err;
    logic [3:0] first_fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -1;

    logic [1:0] X_TBL [8];
    logic [1:0] Z_TBL [8];
    vec_t       vecs [5];

    logic1_seq_checker #(.STEP_CYCLES(SC), .NUM_STEPS(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .z_behav    (z_behav),
        .z_struc    (z_struc),
        .x_out      (x_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .behav_err  (behav_err),
        .struc_err  (struc_err),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cyc = cyc;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x_out"}, x_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_behav_err"}, behav_err, 0);
        chk({tag, "_struc_err"}, struc_err, 0);
        chk({tag, "_first_fail"}, first_fail, 0);
    endtask

    // Run-level reference: score each (pass, step) straight from the expected table.
    task automatic model(input zarr_t zb, input zarr_t zs, output int m_err, output logic m_be,
                         output logic m_se, output logic [3:0] m_ff, output logic m_pass);
        m_err = 0; m_be = 0; m_se = 0; m_ff = 4'd0;
        for (int p = 0; p < PASSES; p++) begin
            for (int s = 0; s < NS; s++) begin
                logic bm, sm;
                bm = (zb[p*8+s] != Z_TBL[s]);
                sm = (zs[p*8+s] != Z_TBL[s]);
                if (bm || sm) begin
                    if (m_err == 0) m_ff = {p[0], s[2:0]};
                    if (m_err < 63) m_err++;
                end
                m_be |= bm;
                m_se |= sm;
            end
        end
        m_pass = (m_err == 0);
    endtask

    task automatic run_case(input zarr_t zb, input zarr_t zs, input bit pulse_mid, input bit pulse_done,
                            output int o_err, output logic o_be, output logic o_se,
                            output logic [3:0] o_ff, output logic o_pass);
        int t0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        for (int p = 0; p < PASSES; p++) begin
            for (int s = 0; s < NS; s++) begin
                for (int c = 0; c < SC; c++) begin
                    z_behav = zb[p*8+s];
                    z_struc = zs[p*8+s];
                    chk("x_out_step", x_out, X_TBL[s]);
                    chk("busy_run", busy, 1);
                    chk("done_early", done, 0);
                    start = pulse_mid && (p == 0) && (s == 3) && (c == 1);
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        chk("done_high", done, 1);
        chk("busy_fall", busy, 0);
        o_err = err_count; o_be = behav_err; o_se = struc_err; o_ff = first_fail; o_pass = pass;
        start = pulse_done;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("latency", done_cyc - t0 + 1, PASSES*NS*SC + 1);
    endtask

    task automatic check_results(input string tag, input int g_err, input logic g_be, input logic g_se,
                                 input logic [3:0] g_ff, input logic g_pass, input int e_err,
                                 input logic e_be, input logic e_se, input logic [3:0] e_ff,
                                 input logic e_pass);
        chk({tag, "_err_count"}, g_err, e_err);
        chk({tag, "_behav_err"}, g_be, e_be);
        chk({tag, "_struc_err"}, g_se, e_se);
        chk({tag, "_first_fail"}, g_ff, e_ff);
        chk({tag, "_pass"}, g_pass, e_pass);
        $display("%s: err_count=%0d behav_err=%0d struc_err=%0d first_fail=%b pass=%0d",
                 tag, g_err, g_be, g_se, g_ff, g_pass);
    endtask

    initial begin
        zarr_t      zb, zs;
        int         g_err, m_err;
        logic       g_be, g_se, g_pass, m_be, m_se, m_pass;
        logic [3:0] g_ff, m_ff;
        int         seen;

        X_TBL = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        Z_TBL = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        vecs[0] = '{bmask:8'h00, bval:2'b00, smask:8'h00, sval:2'b00, err_pp:0, be:0, se:0, ff:4'b0000, pass:1};
        vecs[1] = '{bmask:8'h00, bval:2'b00, smask:8'h04, sval:2'b00, err_pp:1, be:0, se:1, ff:4'b0010, pass:0};
        vecs[2] = '{bmask:8'hFF, bval:2'b11, smask:8'hFF, sval:2'b11, err_pp:7, be:1, se:1, ff:4'b0000, pass:0};
        vecs[3] = '{bmask:8'h01, bval:2'b10, smask:8'h80, sval:2'b01, err_pp:2, be:1, se:1, ff:4'b0000, pass:0};
        vecs[4] = '{bmask:8'h08, bval:2'b10, smask:8'h00, sval:2'b00, err_pp:0, be:0, se:0, ff:4'b0000, pass:1};

        rst = 1'b1; start = 1'b0; z_behav = 2'b00; z_struc = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 16; k++) begin
                zb[k] = vecs[i].bmask[k%8] ? vecs[i].bval : Z_TBL[k%8];
                zs[k] = vecs[i].smask[k%8] ? vecs[i].sval : Z_TBL[k%8];
            end
            run_case(zb, zs, 1'b0, 1'b0, g_err, g_be, g_se, g_ff, g_pass);
            check_results($sformatf("vec%0d", i), g_err, g_be, g_se, g_ff, g_pass,
                          vecs[i].err_pp*PASSES, vecs[i].be, vecs[i].se, vecs[i].ff, vecs[i].pass);
        end

        // Stray start pulses in DRIVE and in DONE must change nothing.
        for (int k = 0; k < 16; k++) begin
            zb[k] = Z_TBL[k%8];
            zs[k] = (k%8 == 2) ? 2'b00 : Z_TBL[k%8];
        end
        run_case(zb, zs, 1'b1, 1'b1, g_err, g_be, g_se, g_ff, g_pass);
        check_results("start_ignored", g_err, g_be, g_se, g_ff, g_pass, PASSES, 1'b0, 1'b1, 4'b0010, 1'b0);

        // Reset in the middle of step 4 aborts without a done pulse.
        z_behav = 2'b11; z_struc = 2'b11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4*SC) @(posedge clk);
        #1;
        chk("abort_x_out_step4", x_out, X_TBL[4]);
        chk("abort_err_before_rst", err_count, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset("abort");
        seen = 0;
        repeat (2*PASSES*NS*SC) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        $display("abort: done pulses after reset=%0d busy=%0d", seen, busy);

`ifdef LOGIC1_SEQ_REPEAT_EN
        for (int k = 0; k < 16; k++) begin
            zb[k] = (k == 13) ? 2'b00 : Z_TBL[k%8];
            zs[k] = Z_TBL[k%8];
        end
        run_case(zb, zs, 1'b0, 1'b0, g_err, g_be, g_se, g_ff, g_pass);
        check_results("repeat_pass2", g_err, g_be, g_se, g_ff, g_pass, 1, 1'b1, 1'b0, 4'b1101, 1'b0);
`endif

        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 16; k++) begin
                zb[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : Z_TBL[k%8];
                zs[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : Z_TBL[k%8];
            end
            model(zb, zs, m_err, m_be, m_se, m_ff, m_pass);
            run_case(zb, zs, 1'b0, 1'b0, g_err, g_be, g_se, g_ff, g_pass);
            check_results($sformatf("rand%0d", r), g_err, g_be, g_se, g_ff, g_pass,
                          m_err, m_be, m_se, m_ff, m_pass);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
